popcount_accum: RTL and testbench

Parametrised successor to the team's 4-input ones-counter. Counts set bits in a WIDTH-bit input word and presents the count as both binary and one-hot outputs. Keeps a running, saturating or wrapping sum of counts across words. Two-stage pipeline with valid tagging and a global stall (ena), for use as a streaming bit-density monitor in Tiny Tapeout designs.

---
 rtl/popcount_accum.sv | 103 ++++++++++
 tb/tb_popcount_accum.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/popcount_accum.sv
// Two-stage popcount pipeline with binary/one-hot outputs and a running
// accumulator of counts that either clamps or wraps on overflow.
`timescale 1ns/1ps
module popcount_accum #(
  parameter int unsigned WIDTH    = 8,
  parameter int unsigned ACC_W    = 12,
  parameter bit          SATURATE = 1'b1,
  localparam int unsigned CNT_W   = $clog2(WIDTH + 1)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               ena,
  input  logic               in_valid,
  input  logic [WIDTH-1:0]   in_data,
  input  logic               clear,
  output logic               out_valid,
  output logic [CNT_W-1:0]   count,
  output logic [WIDTH:0]     onehot,
  output logic [ACC_W-1:0]   acc,
  output logic               acc_sat
);

  localparam int unsigned HALF   = WIDTH / 2;
  localparam int unsigned HALF_W = $clog2(HALF + 1);

  function automatic logic [HALF_W-1:0] pop_half(input logic [HALF-1:0] v);
    logic [HALF_W-1:0] n;
    n = '0;
    for (int i = 0; i < HALF; i++) n = n + HALF_W'(v[i]);
    return n;
  endfunction

  logic              s1_valid;
  logic [HALF_W-1:0] s1_lo, s1_hi;

  logic [HALF_W-1:0] lo_c, hi_c;
  logic [CNT_W-1:0]  sum_c;
  logic [WIDTH:0]    onehot_c;
  logic [ACC_W:0]    acc_sum_c;
  logic [ACC_W-1:0]  acc_nxt_c;
  logic              sat_nxt_c;

  // Half-word popcounts and the full-width stage-2 sum (CNT_W holds WIDTH).
  always_comb begin
    lo_c      = pop_half(in_data[HALF-1:0]);
    hi_c      = pop_half(in_data[WIDTH-1:HALF]);
    sum_c     = CNT_W'(s1_lo) + CNT_W'(s1_hi);
    onehot_c  = (WIDTH + 1)'(1) << sum_c;
    acc_sum_c = (ACC_W + 1)'(acc) + (ACC_W + 1)'(sum_c);
  end

  // Accumulator next state: clear opens a new window, overflow sets the sticky flag.
  always_comb begin
    acc_nxt_c = acc;
    sat_nxt_c = acc_sat;
    if (clear) begin
      acc_nxt_c = s1_valid ? ACC_W'(sum_c) : '0;
      sat_nxt_c = 1'b0;
    end else if (s1_valid) begin
      if (acc_sum_c[ACC_W]) begin
        sat_nxt_c = 1'b1;
        acc_nxt_c = SATURATE ? '1 : acc_sum_c[ACC_W-1:0];
      end else begin
        acc_nxt_c = acc_sum_c[ACC_W-1:0];
      end
    end
  end

  // Stage 1: split popcount.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_lo    <= '0;
      s1_hi    <= '0;
    end else if (ena) begin
      s1_valid <= in_valid;
      if (in_valid) begin
        s1_lo <= lo_c;
        s1_hi <= hi_c;
      end
    end
  end

  // Stage 2: result registers and accumulator.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      count     <= '0;
      onehot    <= '0;
      acc       <= '0;
      acc_sat   <= 1'b0;
    end else if (ena) begin
      out_valid <= s1_valid;
      if (s1_valid) begin
        count  <= sum_c;
        onehot <= onehot_c;
      end
      acc     <= acc_nxt_c;
      acc_sat <= sat_nxt_c;
    end
  end

endmodule

// File: tb/tb_popcount_accum.sv
// Directed bench for popcount_accum: default instance plus 6-bit saturating
// and 6-bit wrapping accumulator instances sharing one stimulus stream.
`timescale 1ns/1ps
module tb_popcount_accum;

  logic       clk = 1'b0;
  logic       rst_n, ena, in_valid, clear;
  logic [7:0] in_data;

  logic       out_valid, acc_sat;
  logic [3:0] count;
  logic [8:0] onehot;
  logic [11:0] acc;

  logic       s_ov, s_sat, w_ov, w_sat;
  logic [3:0] s_cnt, w_cnt;
  logic [8:0] s_oh, w_oh;
  logic [5:0] s_acc, w_acc;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  popcount_accum u_dut (
    .clk(clk), .rst_n(rst_n), .ena(ena), .in_valid(in_valid), .in_data(in_data),
    .clear(clear), .out_valid(out_valid), .count(count), .onehot(onehot),
    .acc(acc), .acc_sat(acc_sat)
  );

  popcount_accum #(.WIDTH(8), .ACC_W(6), .SATURATE(1'b1)) u_sat6 (
    .clk(clk), .rst_n(rst_n), .ena(ena), .in_valid(in_valid), .in_data(in_data),
    .clear(clear), .out_valid(s_ov), .count(s_cnt), .onehot(s_oh),
    .acc(s_acc), .acc_sat(s_sat)
  );

  popcount_accum #(.WIDTH(8), .ACC_W(6), .SATURATE(1'b0)) u_wrap6 (
    .clk(clk), .rst_n(rst_n), .ena(ena), .in_valid(in_valid), .in_data(in_data),
    .clear(clear), .out_valid(w_ov), .count(w_cnt), .onehot(w_oh),
    .acc(w_acc), .acc_sat(w_sat)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [7:0] d, input logic clr, input logic en);
    in_valid = v;
    in_data  = d;
    clear    = clr;
    ena      = en;
  endtask

  task automatic push(input logic [7:0] d);
    drive(1'b1, d, 1'b0, 1'b1);
    tick();
  endtask

  task automatic idle(input logic clr);
    drive(1'b0, 8'h00, clr, 1'b1);
    tick();
  endtask

  task automatic check_out(input string tag, input int cnt, input int acc_exp);
    check({tag, ".valid"}, 32'(out_valid), 32'd1);
    check({tag, ".count"}, 32'(count), 32'(cnt));
    check({tag, ".onehot"}, 32'(onehot), 32'd1 << cnt);
    check({tag, ".acc"}, 32'(acc), 32'(acc_exp));
  endtask

  logic [7:0] words2 [4] = '{8'hFF, 8'h0F, 8'hA5, 8'h01};
  int         cnt2   [4] = '{8, 4, 4, 1};
  int         acc2   [4] = '{8, 12, 16, 17};
  logic [7:0] words3 [6] = '{8'h03, 8'h07, 8'hF0, 8'h80, 8'hFE, 8'h55};
  int         cnt3   [6] = '{2, 3, 4, 1, 7, 4};
  int         acc3   [6] = '{2, 5, 9, 10, 17, 21};
  int         idx3   [11] = '{-1, 0, 1, 1, 1, 1, 2, 3, 4, 5, -1};

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    drive(1'b0, 8'h00, 1'b0, 1'b1);

    // Reset values
    #2;
    check("rst.valid", 32'(out_valid), 32'd0);
    check("rst.count", 32'(count), 32'd0);
    check("rst.onehot", 32'(onehot), 32'd0);
    check("rst.acc", 32'(acc), 32'd0);
    check("rst.sat", 32'(acc_sat), 32'd0);
    #20 rst_n = 1'b1;

    // Single all-zero word: output two enabled edges later, for one cycle
    push(8'h00);
    drive(1'b0, 8'h00, 1'b0, 1'b1);
    check("t1.early", 32'(out_valid), 32'd0);
    tick();
    check_out("t1", 0, 0);
    tick();
    check("t1.drop", 32'(out_valid), 32'd0);

    // Back-to-back words
    for (int i = 0; i < 6; i++) begin
      if (i < 4) drive(1'b1, words2[i], 1'b0, 1'b1);
      else       drive(1'b0, 8'h00, 1'b0, 1'b1);
      tick();
      if (i >= 1 && i <= 4) check_out($sformatf("t2.w%0d", i - 1), cnt2[i-1], acc2[i-1]);
      else if (i == 5)      check("t2.end", 32'(out_valid), 32'd0);
    end

    // Clear with no word in stage 1
    idle(1'b1);
    check("clr.idle.acc", 32'(acc), 32'd0);

    // Stall mid-stream; inputs offered while stalled must be ignored
    begin
      int wi = 0;
      for (int c = 0; c < 11; c++) begin
        if (c >= 3 && c <= 5)  drive(1'b1, 8'hFF, 1'b1, 1'b0);
        else if (wi < 6) begin drive(1'b1, words3[wi], 1'b0, 1'b1); wi++; end
        else                   drive(1'b0, 8'h00, 1'b0, 1'b1);
        tick();
        if (idx3[c] >= 0) check_out($sformatf("t3.c%0d", c), cnt3[idx3[c]], acc3[idx3[c]]);
        else              check($sformatf("t3.c%0d.valid", c), 32'(out_valid), 32'd0);
      end
    end

    // Overflow: 6-bit saturating vs wrapping accumulators
    idle(1'b1);
    check("t4.clr.sat6", 32'(s_acc), 32'd0);
    for (int c = 0; c < 10; c++) begin
      if (c < 9) push(8'hFF);
      else       idle(1'b0);
      if (c >= 1) begin
        int s;
        s = 8 * c;
        check($sformatf("t4.sat6.acc%0d", c), 32'(s_acc), (s > 63) ? 32'd63 : 32'(s));
        check($sformatf("t4.sat6.flag%0d", c), 32'(s_sat), 32'(s > 63));
        check($sformatf("t4.wrap6.acc%0d", c), 32'(w_acc), 32'(s % 64));
        check($sformatf("t4.wrap6.flag%0d", c), 32'(w_sat), 32'(s > 63));
      end
    end

    // Clear timed to a count-3 word in stage 2
    push(8'hFF); push(8'hFF); push(8'hFF); push(8'hFF);
    push(8'h07);
    check("t5.pre.acc", 32'(w_acc), 32'd40);
    check("t5.pre.sat", 32'(w_sat), 32'd1);
    idle(1'b1);
    check("t5.clr.valid", 32'(out_valid), 32'd1);
    check("t5.clr.count", 32'(count), 32'd3);
    check("t5.clr.wacc", 32'(w_acc), 32'd3);
    check("t5.clr.wsat", 32'(w_sat), 32'd0);
    check("t5.clr.sacc", 32'(s_acc), 32'd3);
    check("t5.clr.ssat", 32'(s_sat), 32'd0);
    idle(1'b1);
    check("t5.clr0.acc", 32'(w_acc), 32'd0);

    // Asynchronous reset with two words in flight
    push(8'hFF);
    push(8'h0F);
    #3 rst_n = 1'b0;
    #1;
    check("t6.async.valid", 32'(out_valid), 32'd0);
    check("t6.async.count", 32'(count), 32'd0);
    check("t6.async.onehot", 32'(onehot), 32'd0);
    check("t6.async.acc", 32'(acc), 32'd0);
    check("t6.async.wsat", 32'(w_sat), 32'd0);
    idle(1'b0);
    idle(1'b0);
    #3 rst_n = 1'b1;
    for (int c = 0; c < 3; c++) begin
      idle(1'b0);
      check($sformatf("t6.quiet%0d", c), 32'(out_valid), 32'd0);
    end
    push(8'h3C);
    drive(1'b0, 8'h00, 1'b0, 1'b1);
    check("t6.new.early", 32'(out_valid), 32'd0);
    tick();
    check_out("t6.new", 4, 4);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
